// File: rtl/mem_pingpong_ctrl.sv
// mem_pingpong_ctrl: ping-pong BRAM bank controller with a round-robin writer/reader arbiter.
// Ports: clk, reset (sync, active-high); writer wr_req/wr_data/wr_gnt; reader rd_req/rd_gnt/rd_data/rd_valid;
// BRAM side memoryena {bank,write}, mem_go qualifier, mem_addr, mem_din, mem_dout; bank_full per-bank status.
module mem_pingpong_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  input  logic              rd_req,
  output logic              rd_gnt,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [1:0]        memoryena,
  output logic              mem_go,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [1:0]        bank_full
);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [0:0] LAST_WR = 1'b0;
  localparam logic [0:0] LAST_RD = 1'b1;
  logic              wbank_q, wbank_d, rbank_q, rbank_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic [0:0]        last_q, last_d;
  logic [1:0]        bank_full_q, bank_full_d, memoryena_q, memoryena_d;
  logic              mem_go_q, mem_go_d, rd_pend_q, rd_pend_d, rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d, rd_data_q, rd_data_d;
  logic              wr_elig, rd_elig, wr_wrap, rd_wrap;
  always_comb begin
    wr_elig     = wr_req & ~bank_full_q[wbank_q];
    rd_elig     = rd_req & bank_full_q[rbank_q];
    // On a tie the side that did not win last time goes next.
    wr_gnt      = wr_elig & (~rd_elig | (last_q == LAST_RD));
    rd_gnt      = rd_elig & ~wr_gnt;
    wr_wrap     = wcnt_q == LAST_IDX;
    rd_wrap     = rcnt_q == LAST_IDX;
    wbank_d     = wbank_q ^ (wr_gnt & wr_wrap);
    rbank_d     = rbank_q ^ (rd_gnt & rd_wrap);
    wcnt_d      = wr_gnt ? (wr_wrap ? '0 : wcnt_q + 1'b1) : wcnt_q;
    rcnt_d      = rd_gnt ? (rd_wrap ? '0 : rcnt_q + 1'b1) : rcnt_q;
    bank_full_d = bank_full_q;
    if (wr_gnt & wr_wrap) bank_full_d[wbank_q] = 1'b1;
    if (rd_gnt & rd_wrap) bank_full_d[rbank_q] = 1'b0;
    last_d      = wr_gnt ? LAST_WR : rd_gnt ? LAST_RD : last_q;
    mem_go_d    = wr_gnt | rd_gnt;
    memoryena_d = wr_gnt ? {wbank_q, 1'b1} : rd_gnt ? {rbank_q, 1'b0} : 2'b00;
    mem_addr_d  = wr_gnt ? wcnt_q : rd_gnt ? rcnt_q : mem_addr_q;
    mem_din_d   = wr_gnt ? wr_data : mem_din_q;
    // BRAM answers one cycle after the registered command, so capture mem_dout then.
    rd_pend_d   = rd_gnt;
    rd_valid_d  = rd_pend_q;
    rd_data_d   = rd_pend_q ? mem_dout : rd_data_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wbank_q     <= 1'b0;
      rbank_q     <= 1'b0;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      last_q      <= LAST_RD;
      bank_full_q <= 2'b00;
      memoryena_q <= 2'b00;
      mem_go_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      rd_pend_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      wbank_q     <= wbank_d;
      rbank_q     <= rbank_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      last_q      <= last_d;
      bank_full_q <= bank_full_d;
      memoryena_q <= memoryena_d;
      mem_go_q    <= mem_go_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      rd_pend_q   <= rd_pend_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end
  assign bank_full = bank_full_q;
  assign memoryena = memoryena_q;
  assign mem_go    = mem_go_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
endmodule

// File: tb/tb_mem_pingpong_ctrl.sv
// tb_mem_pingpong_ctrl: directed bench with a BRAM model and a read-data scoreboard queue.
module tb_mem_pingpong_ctrl;
  logic       clk = 1'b0, reset = 1'b1, wr_req = 1'b0, rd_req = 1'b0;
  logic [7:0] wr_data = '0, rd_data, mem_din, mem_dout;
  logic       wr_gnt, rd_gnt, rd_valid, mem_go;
  logic [1:0] memoryena, bank_full;
  logic [3:0] mem_addr;
  logic [7:0] bram [0:1][0:15];
  logic [7:0] exp_q [$];
  logic       exp_rg = 1'b0;
  logic [1:0] vpipe = 2'b00;
  int checks = 0, errors = 0;

  mem_pingpong_ctrl #(.DATA_W(8), .ADDR_W(4), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .wr_req(wr_req), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_data(rd_data), .rd_valid(rd_valid),
    .memoryena(memoryena), .mem_go(mem_go), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .bank_full(bank_full));

  always #5 clk = ~clk;

  // BRAM model: write lands on the edge after the command; read data follows the registered command.
  always @(posedge clk) if (mem_go === 1'b1 && memoryena[0] === 1'b1) bram[memoryena[1]][mem_addr] <= mem_din;
  assign mem_dout = bram[memoryena[1]][mem_addr];

  // Expected rd_valid: two edges after a granted read, cleared by reset.
  always @(posedge clk) vpipe <= reset ? 2'b00 : {vpipe[0], exp_rg};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("rd_valid", {31'd0, rd_valid}, {31'd0, vpipe[1]});
    if (vpipe[1]) begin
      if (exp_q.size() == 0) chk("scoreboard_empty", 32'd1, 32'd0);
      else chk("rd_data", {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
    end
  end

  task automatic chk_reset();
    chk("rst_memoryena", {30'd0, memoryena}, 32'd0);
    chk("rst_mem_go", {31'd0, mem_go}, 32'd0);
    chk("rst_mem_addr", {28'd0, mem_addr}, 32'd0);
    chk("rst_mem_din", {24'd0, mem_din}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
    chk("rst_bank_full", {30'd0, bank_full}, 32'd0);
  endtask

  // One cycle: drive at the falling edge, check grants, then check the registered command after the rising edge.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic ewg, input logic erg,
                     input logic [1:0] ena, input int addr, input logic [7:0] erd, input logic [1:0] ebf);
    wr_req = w; wr_data = d; rd_req = r; exp_rg = erg;
    #1;
    chk("wr_gnt", {31'd0, wr_gnt}, {31'd0, ewg});
    chk("rd_gnt", {31'd0, rd_gnt}, {31'd0, erg});
    if (erg) exp_q.push_back(erd);
    @(posedge clk); #1;
    chk("mem_go", {31'd0, mem_go}, {31'd0, ewg | erg});
    chk("memoryena", {30'd0, memoryena}, (ewg | erg) ? {30'd0, ena} : 32'd0);
    if (ewg | erg) chk("mem_addr", {28'd0, mem_addr}, addr);
    if (ewg) chk("mem_din", {24'd0, mem_din}, {24'd0, d});
    chk("bank_full", {30'd0, bank_full}, {30'd0, ebf});
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 chk_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1, 8'h10 + 8'(i), 0, 1, 0, 2'b01, i, 8'h00, i == 3 ? 2'b01 : 2'b00);
    for (int i = 0; i < 4; i++) cyc(1, 8'h20 + 8'(i), 0, 1, 0, 2'b11, i, 8'h00, i == 3 ? 2'b11 : 2'b01);
    for (int i = 0; i < 2; i++) cyc(1, 8'h24, 0, 0, 0, 2'b00, 0, 8'h00, 2'b11);
    for (int i = 0; i < 4; i++) cyc(1, 8'h24, 1, 0, 1, 2'b00, i, 8'h10 + 8'(i), i == 3 ? 2'b10 : 2'b11);
    // Writer to bank 0 and reader of bank 1 alternate, writer first.
    for (int i = 0; i < 4; i++) begin
      cyc(1, 8'h24 + 8'(i), 1, 1, 0, 2'b01, i, 8'h00, i == 3 ? 2'b11 : 2'b10);
      cyc(1, 8'h30, 1, 0, 1, 2'b10, i, 8'h20 + 8'(i), i == 3 ? 2'b01 : (i == 3 ? 2'b11 : 2'b10));
    end
    // Now bank 0 full, bank 1 empty: memoryena alternates write bank1 / read bank0.
    for (int i = 0; i < 4; i++) begin
      cyc(1, 8'h30 + 8'(i), 1, 1, 0, 2'b11, i, 8'h00, i == 3 ? 2'b11 : 2'b01);
      cyc(1, 8'h40, 1, 0, 1, 2'b00, i, 8'h24 + 8'(i), i == 3 ? 2'b10 : (i == 3 ? 2'b11 : 2'b01));
    end
    for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1, 0, 1, 2'b10, i, 8'h30 + 8'(i), i == 3 ? 2'b00 : 2'b10);
    for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1, 0, 0, 2'b00, 0, 8'h00, 2'b00);
    // Reset one cycle after a read grant: the pending rd_valid must be dropped.
    for (int i = 0; i < 4; i++) cyc(1, 8'h50 + 8'(i), 0, 1, 0, 2'b01, i, 8'h00, i == 3 ? 2'b01 : 2'b00);
    cyc(0, 8'h00, 1, 0, 1, 2'b00, 0, 8'h50, 2'b01);
    reset = 1'b1; wr_req = 1'b0; rd_req = 1'b0; exp_rg = 1'b0;
    exp_q.delete();
    @(posedge clk); #1 chk_reset();
    @(negedge clk);
    reset = 1'b0;
    cyc(1, 8'h66, 0, 1, 0, 2'b01, 0, 8'h00, 2'b00);
    cyc(0, 8'h00, 1, 0, 0, 2'b00, 0, 8'h00, 2'b00);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_pingpong_ctrl.md
Name: mem_pingpong_ctrl

Overview:
- Ping-pong controller for the two BRAM blocks driven by the 2-bit memoryena decode (00 read blk1, 01 write blk1, 10 read blk2, 11 write blk2).
- The deserializer-side writer fills one bank while the serializer-side reader drains the other; banks swap when each side completes a full pass.
- One memory access is issued per cycle. The writer and reader are arbitrated round-robin, and the controller generates memoryena, address, write data and read-valid timing.

Parameters:
- DATA_W, 8, width of memory words.
- ADDR_W, 4, BRAM address width.
- DEPTH, 16, words per bank pass; legal range 2..2^ADDR_W.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- wr_req  in  1  writer requests a write of wr_data.
- wr_data  in  DATA_W  write word; sampled in the cycle wr_gnt=1.
- wr_gnt  out  1  combinational; write accepted this cycle.
- rd_req  in  1  reader requests the next word.
- rd_gnt  out  1  combinational; read accepted this cycle.
- rd_data  out  DATA_W  read word; valid when rd_valid=1.
- rd_valid  out  1  one-cycle pulse, 2 cycles after rd_gnt.
- memoryena  out  2  {bank, write} command to the decoder; registered.
- mem_go  out  1  registered qualifier; memoryena, mem_addr and mem_din are meaningful only when 1.
- mem_addr  out  ADDR_W  registered BRAM address.
- mem_din  out  DATA_W  registered BRAM write data.
- mem_dout  in  DATA_W  BRAM read data; 1-cycle latency after the command.
- bank_full  out  2  bank_full[b]=1 means bank b holds a complete pass not yet drained.

Behaviour:
- Reset values:
  - Outputs: memoryena=00, mem_go=0, mem_addr=0, mem_din=0, rd_valid=0, rd_data=0, bank_full=00.
  - Internal: wbank=0, rbank=0, wcnt=0, rcnt=0, last=RD (writer wins the first tie).
- Eligibility:
  - wr_elig = wr_req & ~bank_full[wbank].
  - rd_elig = rd_req & bank_full[rbank].
- Arbitration:
  - Only one eligible side: it is granted.
  - Both eligible: grant the side not equal to last; last updates on every grant.
  - wr_gnt and rd_gnt are never both 1.
- Write grant, next edge:
  - mem_go=1, memoryena={wbank,1}, mem_addr=wcnt, mem_din=wr_data.
  - If wcnt==DEPTH-1: wcnt=0, bank_full[wbank]=1, wbank toggles. Otherwise wcnt+1.
- Read grant, next edge:
  - mem_go=1, memoryena={rbank,0}, mem_addr=rcnt.
  - If rcnt==DEPTH-1: rcnt=0, bank_full[rbank]=0, rbank toggles. Otherwise rcnt+1.
- Read pipeline: a read command issued at edge t causes rd_valid=1 and rd_data=mem_dout registered at edge t+1. Total latency is 2 cycles from rd_gnt, fixed, with no backpressure.
- No grant: mem_go=0, memoryena=00, mem_addr holds its last value, mem_din holds its last value.
- Stalls:
  - Writer stalls while bank_full[wbank]=1, i.e. both banks are full.
  - Reader stalls while bank_full[rbank]=0.
  - Requesters hold req and data until granted.
- Same-edge events: a final write into bank A and a final read of bank B on the same edge are impossible (one grant per cycle). A final read that clears bank_full[b] makes the writer eligible for bank b on the following cycle, not the same cycle.
- Counters wrap exactly at DEPTH-1, not at 2^ADDR_W.
- Reset mid-operation discards partial passes and any in-flight rd_valid (rd_valid=0 the cycle after reset).

Test Plan (DEPTH=4, DATA_W=8):
- Reset, then wr_req=1 with data 0x10..0x13 -> four consecutive wr_gnt. memoryena=01, mem_addr=0..3, mem_din=0x10..0x13. After the 4th: bank_full=01, wbank=1.
- Continue writing 0x20..0x27 with rd_req=0 -> bank 1 fills (memoryena=11, bank_full=11). Writes 0x24..0x27 get wr_gnt=0 and mem_go=0.
- With both banks full, rd_req=1 for 4 cycles -> memoryena=00 addr 0..3. rd_valid pulses 2 cycles after each grant with rd_data 0x10..0x13. bank_full=10 after the last read. The stalled writer is granted on the next cycle with memoryena=01.
- wr_req and rd_req held continuously, with bank 0 full and bank 1 empty -> grants alternate starting with the writer, and memoryena alternates 00/11 (read bank0, write bank1).
- rd_req=1 with bank_full=00 -> rd_gnt never asserts, mem_go=0, rd_valid stays 0.
- Assert reset one cycle after a rd_gnt -> no rd_valid pulse, and all outputs and bank_full return to reset values.
